// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: latency-class encodings, counter width and bus widths
// shared by the hazard scoreboard and the ID/EXE stages that feed it.
package hazard_scoreboard_pkg;
    localparam logic [1:0] HAZ_CLS_ALU  = 2'd0;
    localparam logic [1:0] HAZ_CLS_LOAD = 2'd1;
    localparam logic [1:0] HAZ_CLS_MUL  = 2'd2;
    localparam logic [1:0] HAZ_CLS_DIV  = 2'd3;

    function automatic int haz_cw(input int load_lat, input int mul_lat);
        return $clog2((load_lat > mul_lat ? load_lat : mul_lat) + 2);
    endfunction

    localparam int HAZ_CW       = haz_cw(1, 2);
    localparam int HAZ_DIV_PEND = (1 << HAZ_CW) - 1;

    // ID bus: rd_addr[2*5], rd_en[2], wr_en, wr_addr[5], wr_class[2], valid
    localparam int HAZ_ID_TO_HAZ_BUS_WD  = 2 * 5 + 2 + 1 + 5 + 2 + 1;
    // EXE bus: div_done, div_dst[5]
    localparam int HAZ_EXE_TO_HAZ_BUS_WD = 1 + 5;
endpackage

// File: rtl/hazard_scoreboard_haz_reg_cnt.sv
// haz_reg_cnt: countdown of one register's outstanding write; all-ones marks a
// pending DIV. Priority: flush > issue load > div clear > decrement.
module haz_reg_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          dec,
    input  logic          div_clr,
    output logic [CW-1:0] cnt
);
    localparam logic [CW-1:0] DIV_PEND = '1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = flush                                          ? '0 :
                ld                                             ? ld_val :
                (div_clr && cnt_q == DIV_PEND)                 ? '0 :
                (dec && cnt_q != '0 && cnt_q != DIV_PEND)      ? cnt_q - 1'b1 :
                                                                 cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard producing ID ready_go and
// per-port stall flags. HAZ_PERF_CNT_EN adds a saturating stall_cycles counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_RD   = 2,
    parameter int REG_NUM  = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [NUM_RD*AW-1:0] id_rd_addr,
    input  logic [NUM_RD-1:0]  id_rd_en,
    input  logic               id_wr_en,
    input  logic [AW-1:0]      id_wr_addr,
    input  logic [1:0]         id_wr_class,
    input  logic               exe_allowin,
    input  logic               pipe_adv,
    input  logic               div_done,
    input  logic [AW-1:0]      div_dst,
    input  logic               flush,
    output logic               id_ready_go,
    output logic [NUM_RD-1:0]  rd_stall,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]        stall_cycles,
`endif
    output logic               div_busy
);
    localparam int CW = haz_cw(LOAD_LAT, MUL_LAT);

    logic [CW-1:0] cnt [REG_NUM];
    logic [CW-1:0] ld_val;
    logic          div_block, issue;
    logic          div_busy_q, div_busy_d;

    assign cnt[0] = '0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
        haz_reg_cnt #(.CW(CW)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush),
            .ld     (issue && id_wr_addr == AW'(r)),
            .ld_val (ld_val),
            .dec    (pipe_adv),
            .div_clr(div_done && div_dst == AW'(r)),
            .cnt    (cnt[r])
        );
    end

    always_comb begin
        rd_stall = '0;
        for (int k = 0; k < NUM_RD; k++)
            rd_stall[k] = id_valid && id_rd_en[k] && id_rd_addr[k*AW+:AW] != '0 &&
                          cnt[id_rd_addr[k*AW+:AW]] != '0;
    end

    always_comb begin
        // a second DIV cannot issue while the single divider is still busy
        div_block   = id_valid && id_wr_en && id_wr_class == HAZ_CLS_DIV && div_busy_q;
        id_ready_go = ~|rd_stall && !div_block;
        issue       = id_valid && id_ready_go && exe_allowin && id_wr_en && !flush;
        ld_val      = id_wr_class == HAZ_CLS_LOAD ? CW'(LOAD_LAT) :
                      id_wr_class == HAZ_CLS_MUL  ? CW'(MUL_LAT)  :
                      id_wr_class == HAZ_CLS_DIV  ? '1 : '0;
        div_busy_d  = flush                                  ? 1'b0 :
                      (issue && id_wr_class == HAZ_CLS_DIV)  ? 1'b1 :
                      div_done                               ? 1'b0 : div_busy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_busy_q <= 1'b0;
        else       div_busy_q <= div_busy_d;
    end

    assign div_busy = div_busy_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = (id_valid && !id_ready_go && stall_cycles_q != '1) ?
                         stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed tests of the hazard scoreboard with
// hand-computed expectations (default configuration: LOAD_LAT=1, MUL_LAT=2).
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rd_addr = '0;
    logic [1:0]  id_rd_en = '0;
    logic        id_wr_en = 1'b0;
    logic [4:0]  id_wr_addr = '0;
    logic [1:0]  id_wr_class = '0;
    logic        exe_allowin = 1'b0;
    logic        pipe_adv = 1'b0;
    logic        div_done = 1'b0;
    logic [4:0]  div_dst = '0;
    logic        flush = 1'b0;
    logic        id_ready_go;
    logic [1:0]  rd_stall;
    logic        div_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int tests = 0;
    int fails = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd_addr(id_rd_addr),
        .id_rd_en(id_rd_en), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_wr_class(id_wr_class), .exe_allowin(exe_allowin), .pipe_adv(pipe_adv),
        .div_done(div_done), .div_dst(div_dst), .flush(flush),
        .id_ready_go(id_ready_go), .rd_stall(rd_stall),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rd_en = '0; id_rd_addr = '0; id_wr_en = 0;
        id_wr_addr = '0; id_wr_class = '0; exe_allowin = 1; div_done = 0;
        div_dst = '0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [1:0] cls, input logic adv);
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = a; id_wr_class = cls; pipe_adv = adv;
        step();
        idle();
    endtask

    task automatic read(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0);
        idle();
        id_valid = 1; id_rd_en = en; id_rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        issue(5'd3, 2'd1, 1'b0);
        @(posedge clk);
        #2;
        reset = 1;
        read(2'b11, 5'd4, 5'd3);
        tests++; if (id_ready_go !== 1'b1) begin fails++; $display("FAIL reset_ready_go got=%b exp=1", id_ready_go); end
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL reset_rd_stall got=%b exp=00", rd_stall); end
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL reset_div_busy got=%b exp=0", div_busy); end
        #2;
        reset = 0;
        step();
    endtask

    task automatic test_load_use();
        issue(5'd5, 2'd1, 1'b1);
        read(2'b10, 5'd5, 5'd0);
        tests++; if (rd_stall !== 2'b10) begin fails++; $display("FAIL load_use_stall got=%b exp=10", rd_stall); end
        tests++; if (id_ready_go !== 1'b0) begin fails++; $display("FAIL load_use_ready got=%b exp=0", id_ready_go); end
        step();
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL load_use_clear got=%b exp=00", rd_stall); end
        tests++; if (id_ready_go !== 1'b1) begin fails++; $display("FAIL load_use_go got=%b exp=1", id_ready_go); end
        step();
    endtask

    task automatic test_mul_stall();
        issue(5'd7, 2'd2, 1'b1);
        pipe_adv = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) pipe_adv = 1;
            read(2'b01, 5'd0, 5'd7);
            tests++; if (rd_stall !== 2'b01) begin fails++; $display("FAIL mul_stall_cyc%0d got=%b exp=01", i, rd_stall); end
            step();
        end
        read(2'b01, 5'd0, 5'd7);
        tests++; if (rd_stall !== 2'b00 || id_ready_go !== 1'b1) begin fails++; $display("FAIL mul_release got=%b/%b exp=00/1", rd_stall, id_ready_go); end
        step();
        issue(5'd7, 2'd2, 1'b0);
        pipe_adv = 0;
        issue(5'd7, 2'd0, 1'b0);
        read(2'b01, 5'd0, 5'd7);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL mul_alu_overwrite got=%b exp=00", rd_stall); end
        step();
    endtask

    task automatic test_div();
        issue(5'd9, 2'd3, 1'b1);
        pipe_adv = 1;
        for (int i = 0; i < 4; i++) begin
            read(2'b10, 5'd9, 5'd0);
            tests++; if (rd_stall !== 2'b10 || div_busy !== 1'b1) begin fails++; $display("FAIL div_pending_cyc%0d got=%b/%b exp=10/1", i, rd_stall, div_busy); end
            step();
        end
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 5'd10; id_wr_class = 2'd3;
        #1;
        tests++; if (id_ready_go !== 1'b0 || rd_stall !== 2'b00) begin fails++; $display("FAIL div_second_block got=%b/%b exp=0/00", id_ready_go, rd_stall); end
        step();
        idle();
        div_done = 1; div_dst = 5'd9;
        step();
        read(2'b11, 5'd10, 5'd9);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL div_done_clear got=%b exp=00", rd_stall); end
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL div_done_busy got=%b exp=0", div_busy); end
        step();
    endtask

    task automatic test_flush();
        issue(5'd5, 2'd1, 1'b0);
        pipe_adv = 0;
        issue(5'd9, 2'd3, 1'b0);
        read(2'b11, 5'd9, 5'd5);
        tests++; if (rd_stall !== 2'b11 || div_busy !== 1'b1) begin fails++; $display("FAIL flush_pre got=%b/%b exp=11/1", rd_stall, div_busy); end
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 5'd2; id_wr_class = 2'd2; flush = 1;
        step();
        read(2'b11, 5'd9, 5'd5);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL flush_clear got=%b exp=00", rd_stall); end
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL flush_div_busy got=%b exp=0", div_busy); end
        read(2'b01, 5'd0, 5'd2);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL flush_suppress_issue got=%b exp=00", rd_stall); end
        step();
    endtask

    task automatic test_r0_waw();
        pipe_adv = 0;
        issue(5'd0, 2'd1, 1'b0);
        read(2'b11, 5'd0, 5'd0);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL r0_no_stall got=%b exp=00", rd_stall); end
        step();
        issue(5'd6, 2'd2, 1'b0);
        read(2'b10, 5'd6, 5'd0);
        tests++; if (rd_stall !== 2'b10) begin fails++; $display("FAIL waw_mul_pending got=%b exp=10", rd_stall); end
        issue(5'd6, 2'd2, 1'b0);
        issue(5'd6, 2'd0, 1'b0);
        read(2'b10, 5'd6, 5'd0);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL waw_alu_wins got=%b exp=00", rd_stall); end
        step();
    endtask

    task automatic test_no_allowin();
        pipe_adv = 0;
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 5'd11; id_wr_class = 2'd2; exe_allowin = 0;
        step();
        read(2'b01, 5'd0, 5'd11);
        tests++; if (rd_stall !== 2'b00) begin fails++; $display("FAIL no_allowin_issue got=%b exp=00", rd_stall); end
        step();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        idle();
        #2 reset = 1;
        #2 reset = 0;
        step();
        tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL perf_reset got=%0d exp=0", stall_cycles); end
        issue(5'd7, 2'd2, 1'b1);
        pipe_adv = 1;
        for (int i = 0; i < 3; i++) begin
            read(2'b01, 5'd0, 5'd7);
            step();
        end
        idle();
        #1;
        tests++; if (stall_cycles !== 32'd2) begin fails++; $display("FAIL perf_count got=%0d exp=2", stall_cycles); end
    endtask
`endif

    initial begin
        idle();
        exe_allowin = 1;
        #12 reset = 0;
        step();
        test_reset();
        test_load_use();
        test_mul_stall();
        test_div();
        test_flush();
        test_r0_waw();
        test_no_allowin();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-port load-use stall check in the ID stage.
- Tracks every architectural register with an outstanding write in a per-register countdown scoreboard.
- Covers latency classes ALU, LOAD, fixed-latency MUL and variable-latency DIV.
- Generates the ID-stage ready_go and per-read-port stall flags from scoreboard state, for any number of read ports.

Parameters:
- NUM_RD, 2, number of ID register read ports checked.
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width, clog2(REG_NUM).
- LOAD_LAT, 1, bubble cycles before a load result is forwardable.
- MUL_LAT, 2, bubble cycles before a multiply result is forwardable.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW+:AW].
- id_rd_en  in  NUM_RD  read-port enables.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_addr  in  AW  destination register.
- id_wr_class  in  2  latency class: 0 ALU, 1 LOAD, 2 MUL, 3 DIV.
- exe_allowin  in  1  EXE accepts an instruction this cycle.
- pipe_adv  in  1  downstream stages advanced this cycle.
- div_done  in  1  divider result forwardable next cycle.
- div_dst  in  AW  divider destination register.
- flush  in  1  pipeline flush (exception or ERET).
- id_ready_go  out  1  ID may issue.
- rd_stall  out  NUM_RD  per-port hazard flags.
- div_busy  out  1  a DIV is outstanding.

Behaviour:
- Reset (asynchronous, active-high):
  - All counters = 0, div_busy = 0.
  - Outputs: id_ready_go = 1, rd_stall = 0.
- State: cnt[r], width CW = clog2(max(LOAD_LAT, MUL_LAT) + 2). All-ones is the DIV_PEND sentinel. cnt[0] is always 0 and writes to it are ignored.
- rd_stall[k] = id_valid & id_rd_en[k] & (addr_k != 0) & (cnt[addr_k] != 0). Combinational from current state only.
- id_ready_go = ~|rd_stall, except that issuing a DIV while div_busy = 1 also forces id_ready_go = 0.
- issue = id_valid & id_ready_go & exe_allowin & id_wr_en & ~flush.
- On issue, cnt[id_wr_addr] is loaded at the clock edge as:
  - ALU: 0.
  - LOAD: LOAD_LAT.
  - MUL: MUL_LAT.
  - DIV: DIV_PEND, and div_busy is set.
- A new issue overwrites an existing entry (WAW): the youngest write wins, because forwarding selects the youngest producer.
- Decrement: when pipe_adv = 1, every cnt that is non-zero and not DIV_PEND decrements by 1. Counters hold when pipe_adv = 0.
- div_done: cnt[div_dst] goes DIV_PEND -> 0 and div_busy clears. If cnt[div_dst] is not DIV_PEND, only div_busy clears.
- Simultaneous issue and decrement/div_done on the same register: the issue load wins.
- Same-cycle read and issue: the issuing instruction's own reads are checked against pre-update state.
- flush: synchronously clears all counters and div_busy on the next edge; issue is suppressed that cycle. Flush has priority over issue, decrement and div_done.
- Latency: zero-cycle combinational stall decision; one-cycle state update.
- Reset mid-DIV clears state. div_done after reset is then harmless because div_busy is already 0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles, 32 bits.
  - Increments each cycle id_valid & ~id_ready_go.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0; not cleared by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - Class encodings HAZ_CLS_ALU/LOAD/MUL/DIV.
  - CW computation and the DIV_PEND constant.
  - Bus-width defines for the ID/EXE-to-hazard buses, alongside the existing bus-width header.
- One sub-module, haz_reg_cnt: a single register's counter with load/decrement/div_clear/flush priority. It is instantiated REG_NUM-1 times via generate; the top level does the read-port compare and reduction.

Test Plan:
- Reset:
  - Assert reset mid-cycle, drive id_valid=1 with rd_en=2'b11, addrs 3 and 4.
  - Required: id_ready_go=1 immediately; rd_stall=0.
- Load-use:
  - Issue LOAD to r5 with pipe_adv=1 every cycle. Next cycle, read r5 on port 1.
  - Required: rd_stall=2'b10 for exactly 1 cycle, then id_ready_go=1.
- MUL with stall:
  - Issue MUL to r7, hold pipe_adv=0 for 3 cycles, then pipe_adv=1. Read r7.
  - Required: stall lasts 3+2 cycles.
  - Required: ALU write to r7 issued later overwrites the entry to 0.
- DIV:
  - Issue DIV to r9; read r9 stalls indefinitely; a second DIV stalls on div_busy.
  - Pulse div_done with div_dst=9. Required: next cycle stall clears and div_busy=0.
- Flush priority:
  - With r5=LOAD pending and r9=DIV pending, assert flush together with an issue to r2 (MUL).
  - Required: all counters 0 next cycle, r2 not busy, div_busy=0.
- r0 and WAW:
  - LOAD to r0 followed by a read of r0 -> no stall.
  - MUL r6 then ALU r6 back-to-back -> read of r6 does not stall.
  - With HAZ_PERF_CNT_EN defined, stall_cycles matches the counted stall cycles.
